seq_accum_16bit: RTL and testbench
==================================

Name: seq_accum_16bit

Overview:
Sequential multi-operand accumulator that sums a group of NUM_OPS 16-bit operands streamed in one per cycle. It is the stage that drives rca_2op_16bit: the running low word and the new operand are fed to one rca_2op_16bit instance (A = acc_lo, B = in_data, Cin = 0). The carry-out S[16] increments a high-word counter. Input and output use valid/ready handshakes so the block sits between an operand source and a result consumer.

Parameters:
NUM_OPS, 4, operands per group; legal range 2..256.
OUT_W, 16+$clog2(NUM_OPS), derived localparam, not overridable; result width; holds NUM_OPS*16'hFFFF without overflow.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
clr  input  1  synchronous abort; discards the current group and any pending result.
in_valid  input  1  in_data is valid.
in_ready  output  1  block accepts an operand this cycle.
in_data  input  16  operand.
out_valid  output  1  out_sum holds a completed group sum.
out_ready  input  1  consumer accepts out_sum.
out_sum  output  OUT_W  group sum, zero-extended.
out_cnt  output  8  number of operands accepted in the current group (debug/verification).

Behaviour:
- Reset (async assert, sync release by clk): state=ACCUM, acc_lo=0, acc_hi=0, cnt=0, out_valid=0, out_sum=0, out_cnt=0. in_ready=1 from the first edge after reset deassertion.
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Accept: an operand is taken when in_valid && in_ready; none is taken otherwise, and the accumulator holds.
- State ACCUM: in_ready=1, out_valid=0. On accept:
  - acc_lo <= S[15:0].
  - acc_hi <= acc_hi + S[16].
  - cnt <= cnt+1.
  - If cnt==NUM_OPS-1: out_sum <= {acc_hi+S[16], S[15:0]}, next state DONE.
- State DONE: in_ready=0, out_valid=1, out_sum held stable. On out_ready: acc_lo, acc_hi and cnt are cleared, next state ACCUM. The first operand of the next group is accepted no earlier than the following cycle.
- Latency: out_valid rises on the clock edge that accepts the final operand, so it is visible the cycle after that operand's handshake.
- Throughput: NUM_OPS operands plus one handshake cycle per group at best.
- Backpressure: while out_valid && !out_ready, out_sum and out_valid are held stable and no operands are accepted.
- clr: takes priority over accept and out_ready in every state. Effect: state=ACCUM, acc and cnt cleared, out_valid=0. An operand presented in the same cycle as clr is dropped; in_ready is still 1 that cycle in ACCUM.
- rst mid-group or mid-DONE: all state is discarded immediately and the block behaves as after reset.
- out_cnt mirrors cnt; it reads NUM_OPS-1 in the cycle the final operand is accepted, then 0 after out_ready.
- Arithmetic: unsigned only. acc_hi is OUT_W-16 bits and cannot wrap for legal NUM_OPS.
- The rca_2op_16bit instance is purely combinational. The only registers are acc_lo, acc_hi, cnt, state and out_sum.

Test Plan:
- NUM_OPS=4, operands 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=18'h0000A, in_ready=0 for one cycle, then 1.
- NUM_OPS=4, four operands of 16'hFFFF -> out_sum=18'h3FFFC. Checks carry propagation from S[16] into acc_hi on accepts 2, 3 and 4.
- Gapped in_valid (operands 16'h8000, idle, 16'h8000, idle idle, 16'h0001, 16'h0001) -> only handshaken operands counted, out_sum=18'h10002.
- Backpressure: out_ready=0 for 5 cycles after completion, in_valid held high -> out_sum held stable, in_ready=0, no operand absorbed. out_ready=1 -> next group starts from 0.
- clr asserted after 2 of 4 operands (values 100, 200) with in_valid high, then operands 5,5,5,5 -> the operand in the clr cycle is dropped, out_sum=20.
- rst pulsed asynchronously (not edge-aligned) mid-group and during DONE -> outputs 0 immediately, out_cnt=0. The next full group sums correctly.
- NUM_OPS=2 (OUT_W=17): 16'hFFFF + 16'h0001 -> out_sum=17'h10000.

Source files
------------

// File: rtl/seq_accum_16bit.sv
// ---------------------------------------------------------------------------
// seq_accum_16bit
//
// Purpose:
//   Sequential multi-operand accumulator. It sums a group of NUM_OPS unsigned
//   16-bit operands, taking at most one operand per cycle. The running low
//   word and the incoming operand go through a single combinational 16-bit
//   ripple-carry adder (rca_2op_16bit). Each carry-out of that adder bumps a
//   high-word counter, so the full group sum never overflows.
//
//   Both sides use valid/ready handshakes. After a group completes, the block
//   holds the result until the consumer accepts it. It then clears itself and
//   starts the next group on the following cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   clr        in   1      synchronous abort (drops current group / result)
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      an operand is accepted this cycle if in_valid
//   in_data    in   16     operand
//   out_valid  out  1      out_sum holds a completed group sum
//   out_ready  in   1      consumer accepts out_sum
//   out_sum    out  OUT_W  group sum, zero-extended
//   out_cnt    out  8      operands accepted so far in the current group
// ---------------------------------------------------------------------------

// Purely combinational 16-bit two-operand ripple-carry adder.
// The outputs are S[15:0] = sum and S[16] = carry-out.
module rca_2op_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [16:0] s_o
);

  logic [16:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit. The carry ripples from bit 0 upward.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign s_o[16] = carry[16];

endmodule

module seq_accum_16bit #(
  parameter  int NUM_OPS = 4,
  localparam int OUT_W   = 16 + $clog2(NUM_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [7:0]       out_cnt
);

  localparam int       HI_W     = OUT_W - 16;
  localparam bit [7:0] LAST_CNT = 8'(NUM_OPS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        accLo_q, accLo_d;
  logic [HI_W-1:0]    accHi_q, accHi_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]   outSum_q, outSum_d;

  logic [16:0]        rcaSum;
  logic               accept;

  // The running low word plus the new operand, with no carry-in.
  rca_2op_16bit u_rca (
    .a_i   (accLo_q),
    .b_i   (in_data),
    .cin_i (1'b0),
    .s_o   (rcaSum)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign out_sum   = outSum_q;
  assign out_cnt   = cnt_q;

  // Next-state logic. The default is to hold everything. An accepted operand
  // folds into the accumulator, and the last operand of a group also latches
  // the full sum. clr is applied last so that it overrides every other action.
  always_comb begin
    state_d  = state_q;
    accLo_d  = accLo_q;
    accHi_d  = accHi_q;
    cnt_d    = cnt_q;
    outSum_d = outSum_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          accLo_d = rcaSum[15:0];
          accHi_d = accHi_q + HI_W'(rcaSum[16]);
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            outSum_d = {accHi_d, rcaSum[15:0]};
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          accLo_d = '0;
          accHi_d = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clr) begin
      state_d  = ACCUM;
      accLo_d  = '0;
      accHi_d  = '0;
      cnt_d    = '0;
      outSum_d = '0;
    end
  end

  // State and datapath registers. Reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      accLo_q  <= '0;
      accHi_q  <= '0;
      cnt_q    <= '0;
      outSum_q <= '0;
    end else begin
      state_q  <= state_d;
      accLo_q  <= accLo_d;
      accHi_q  <= accHi_d;
      cnt_q    <= cnt_d;
      outSum_q <= outSum_d;
    end
  end

endmodule

// File: tb/tb_seq_accum_16bit.sv
// ---------------------------------------------------------------------------
// tb_seq_accum_16bit
//
// Directed testbench for seq_accum_16bit. The main instance uses NUM_OPS=4.
// A second instance uses NUM_OPS=2 to cover the narrow 17-bit result.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled there as well.
// ---------------------------------------------------------------------------
module tb_seq_accum_16bit;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sum;
  logic [7:0]  out_cnt;

  logic        in2_valid;
  logic        in2_ready;
  logic [15:0] in2_data;
  logic        out2_valid;
  logic        out2_ready;
  logic [16:0] out2_sum;
  logic [7:0]  out2_cnt;

  int checks   = 0;
  int failures = 0;

  seq_accum_16bit #(.NUM_OPS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt)
  );

  seq_accum_16bit #(.NUM_OPS(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .in_valid  (in2_valid),
    .in_ready  (in2_ready),
    .in_data   (in2_data),
    .out_valid (out2_valid),
    .out_ready (out2_ready),
    .out_sum   (out2_sum),
    .out_cnt   (out2_cnt)
  );

  // Free-running clock, 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on a miscompare counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs into the NUM_OPS=4 instance, then step past the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic ordy, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in2_valid  = 1'b0;
    in2_data   = '0;
    out2_ready = 1'b1;

    // Reset, then release away from the clock edge.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sum", 32'(out_sum), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'h1);
    checkOutput("post_rst_cnt", 32'(out_cnt), 32'h0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'h0);

    // Group 1,2,3,4 on consecutive cycles.
    applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
    checkOutput("g1_cnt1", 32'(out_cnt), 32'h1);
    applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
    checkOutput("g1_cnt_last", 32'(out_cnt), 32'h3);
    checkOutput("g1_valid_early", 32'(out_valid), 32'h0);
    applyStimulus(1'b1, 16'd4, 1'b1, 1'b0);
    checkOutput("g1_valid", 32'(out_valid), 32'h1);
    checkOutput("g1_sum", 32'(out_sum), 32'h0000A);
    checkOutput("g1_ready_low", 32'(in_ready), 32'h0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkOutput("g1_ready_back", 32'(in_ready), 32'h1);
    checkOutput("g1_valid_drop", 32'(out_valid), 32'h0);
    checkOutput("g1_cnt_clear", 32'(out_cnt), 32'h0);

    // Four 0xFFFF operands exercise the carry into the high word.
    repeat (4) applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
    checkOutput("g2_valid", 32'(out_valid), 32'h1);
    checkOutput("g2_sum", 32'(out_sum), 32'h3FFFC);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // Gapped in_valid: idle cycles carry junk data that must not be absorbed.
    applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h1234, 1'b0, 1'b0);
    checkOutput("g3_cnt_idle", 32'(out_cnt), 32'h1);
    applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h4321, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("g3_cnt_idle2", 32'(out_cnt), 32'h2);
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
    checkOutput("g3_sum", 32'(out_sum), 32'h10002);

    // Backpressure: hold out_ready low while offering operands.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_sum", 32'(out_sum), 32'h10002);
      checkOutput("bp_ready", 32'(in_ready), 32'h0);
      checkOutput("bp_cnt", 32'(out_cnt), 32'h4);
    end
    applyStimulus(1'b1, 16'h0007, 1'b1, 1'b0);
    checkOutput("bp_release_valid", 32'(out_valid), 32'h0);
    checkOutput("bp_release_cnt", 32'(out_cnt), 32'h0);
    repeat (4) applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
    checkOutput("g4_sum", 32'(out_sum), 32'h4);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // clr after two operands. The operand offered in the clr cycle is dropped.
    applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'd200, 1'b1, 1'b0);
    checkOutput("clr_ready", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 16'd999, 1'b1, 1'b1);
    checkOutput("clr_cnt", 32'(out_cnt), 32'h0);
    repeat (4) applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    checkOutput("clr_group_sum", 32'(out_sum), 32'h14);
    checkOutput("clr_group_valid", 32'(out_valid), 32'h1);
    // clr while the result is waiting discards it.
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
    checkOutput("clr_done_valid", 32'(out_valid), 32'h0);
    checkOutput("clr_done_ready", 32'(in_ready), 32'h1);
    checkOutput("clr_done_cnt", 32'(out_cnt), 32'h0);

    // Asynchronous reset in the middle of a group.
    repeat (3) applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_mid_cnt", 32'(out_cnt), 32'h0);
    checkOutput("arst_mid_valid", 32'(out_valid), 32'h0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd4, 1'b0, 1'b0);
    checkOutput("arst_group_sum", 32'(out_sum), 32'h0000A);
    checkOutput("arst_group_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset while the result is waiting.
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_done_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_done_sum", 32'(out_sum), 32'h0);
    checkOutput("arst_done_cnt", 32'(out_cnt), 32'h0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    checkOutput("arst_next_sum", 32'(out_sum), 32'h10000);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

    // NUM_OPS=2 instance with a 17-bit result: 0xFFFF + 0x0001.
    in2_valid = 1'b1;
    in2_data  = 16'hFFFF;
    @(posedge clk);
    #1;
    in2_data  = 16'h0001;
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
    checkOutput("n2_valid", 32'(out2_valid), 32'h1);
    checkOutput("n2_sum", 32'(out2_sum), 32'h10000);
    checkOutput("n2_ready", 32'(in2_ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("n2_release", 32'(out2_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
